// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and
// single-cycle press/release/long-press/auto-repeat event pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int REPEAT_CYCLES     = 25_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse
);

    // state       | meaning
    // IDLE        | released and stable
    // PRESS_CHK   | btn_s high, counting stable cycles before accepting a press
    // PRESSED     | accepted press; hold counter running
    // RELEASE_CHK | btn_s low, counting stable cycles; hold counter frozen
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW      = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [DW-1:0] DB_ONE   = DW'(1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_db_cnt, w_db_cnt_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [RW-1:0] r_rep_cnt, w_rep_cnt_nxt;
    logic          w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt;
    logic          w_btn_s;

    assign w_btn_s = r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_state         <= IDLE;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_rep_cnt       <= '0;
            o_btn_level     <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
        end else begin
            r_sync1         <= i_btn_raw;
            r_sync2         <= r_sync1;
            r_state         <= w_state_nxt;
            r_db_cnt        <= w_db_cnt_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_rep_cnt       <= w_rep_cnt_nxt;
            o_btn_level     <= w_level_nxt;
            o_press_pulse   <= w_press_nxt;
            o_release_pulse <= w_release_nxt;
            o_long_pulse    <= w_long_nxt;
            o_repeat_pulse  <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_db_cnt_nxt   = r_db_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_level_nxt    = o_btn_level;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_long_nxt     = 1'b0;
        w_repeat_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_level_nxt  = 1'b0;
                w_db_cnt_nxt = '0;
                if (w_btn_s) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        w_state_nxt    = PRESSED;
                        w_press_nxt    = 1'b1;
                        w_level_nxt    = 1'b1;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = PRESS_CHK;
                        w_db_cnt_nxt = DB_ONE;
                    end
                end
            end

            PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_state_nxt  = IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt    = PRESSED;
                    w_press_nxt    = 1'b1;
                    w_level_nxt    = 1'b1;
                    w_hold_cnt_nxt = '0;
                    w_db_cnt_nxt   = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_ONE;
                end
            end

            PRESSED: begin
                // Hold counter saturates at the long-press point; repeat timing
                // then runs on its own down-counter.
                if (r_hold_cnt != HOLD_MAX) begin
                    w_hold_cnt_nxt = r_hold_cnt + HW'(1);
                    if (r_hold_cnt == HOLD_PRE) begin
                        w_long_nxt    = 1'b1;
                        w_rep_cnt_nxt = REP_LOAD;
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (r_rep_cnt == REP_ONE) begin
                        w_repeat_nxt  = 1'b1;
                        w_rep_cnt_nxt = REP_LOAD;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt - REP_ONE;
                    end
                end
                if (!w_btn_s) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        w_state_nxt   = IDLE;
                        w_release_nxt = 1'b1;
                        w_level_nxt   = 1'b0;
                        w_long_nxt    = 1'b0;
                        w_repeat_nxt  = 1'b0;
                    end else begin
                        w_state_nxt  = RELEASE_CHK;
                        w_db_cnt_nxt = DB_ONE;
                    end
                end
            end

            RELEASE_CHK: begin
                if (w_btn_s) begin
                    w_state_nxt  = PRESSED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                    w_db_cnt_nxt  = '0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
